// File: rtl/video_timing_pkg.sv
// Shared constants and FSM state type for the HDMI raster timing sequencer.
// Defaults describe 1280x720p60 (1650x750 total raster).
package video_timing_pkg;

  localparam int H_CNT_W = 11;
  localparam int V_CNT_W = 10;

  localparam int DEF_H_ACTIVE = 1280;
  localparam int DEF_H_FRONT  = 110;
  localparam int DEF_H_SYNC   = 40;
  localparam int DEF_H_BACK   = 220;

  localparam int DEF_V_ACTIVE = 720;
  localparam int DEF_V_FRONT  = 5;
  localparam int DEF_V_SYNC   = 5;
  localparam int DEF_V_BACK   = 20;

  localparam int DEF_H_TOTAL      = DEF_H_ACTIVE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL      = DEF_V_ACTIVE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
  localparam int DEF_H_SYNC_START = DEF_H_ACTIVE + DEF_H_FRONT;
  localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;
  localparam int DEF_V_SYNC_START = DEF_V_ACTIVE + DEF_V_FRONT;
  localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seqState_e;

endpackage

// File: rtl/timing_axis_counter.sv
// One raster axis: a wrapping position counter plus decodes of its next value,
// so the parent can register flags that line up with the registered count.
module timing_axis_counter
  import video_timing_pkg::*;
#(
  parameter int WIDTH  = H_CNT_W,
  parameter int TOTAL  = DEF_H_TOTAL,
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FRONT  = DEF_H_FRONT,
  parameter int SYNC   = DEF_H_SYNC
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             clear_i,
  input  logic             advance_i,
  output logic [WIDTH-1:0] count_o,
  output logic [WIDTH-1:0] countNext_o,
  output logic             wrap_o,
  output logic             activeNext_o,
  output logic             syncNext_o
);

  // Extended by one bit so a sync window ending exactly at TOTAL still compares correctly.
  localparam logic [WIDTH:0] LAST_EXT       = (WIDTH+1)'(TOTAL - 1);
  localparam logic [WIDTH:0] ACTIVE_EXT     = (WIDTH+1)'(ACTIVE);
  localparam logic [WIDTH:0] SYNC_START_EXT = (WIDTH+1)'(ACTIVE + FRONT);
  localparam logic [WIDTH:0] SYNC_END_EXT   = (WIDTH+1)'(ACTIVE + FRONT + SYNC);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH:0]   nextExt;

  assign wrap_o = ({1'b0, count_q} == LAST_EXT);

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (advance_i) begin
      count_d = wrap_o ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign nextExt      = {1'b0, count_d};
  assign count_o      = count_q;
  assign countNext_o  = count_d;
  assign activeNext_o = (nextExt < ACTIVE_EXT);
  assign syncNext_o   = (nextExt >= SYNC_START_EXT) && (nextExt < SYNC_END_EXT);

endmodule

// File: rtl/video_timing_sequencer.sv
// HDMI raster timing generator: position counters, syncs, data enable and frame/line
// pulses, started and stopped only on frame boundaries via a level runEnable.
module video_timing_sequencer
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE         = DEF_H_ACTIVE,
  parameter int H_FRONT          = DEF_H_FRONT,
  parameter int H_SYNC           = DEF_H_SYNC,
  parameter int H_BACK           = DEF_H_BACK,
  parameter int V_ACTIVE         = DEF_V_ACTIVE,
  parameter int V_FRONT          = DEF_V_FRONT,
  parameter int V_SYNC           = DEF_V_SYNC,
  parameter int V_BACK           = DEF_V_BACK,
  parameter bit SYNC_ACTIVE_HIGH = 1'b1
) (
  input  logic               pixelCLK,
  input  logic               reset,
  input  logic               runEnable,
  output logic               running,
  output logic [H_CNT_W-1:0] hPosCounter,
  output logic [V_CNT_W-1:0] vPosCounter,
  output logic               hSync,
  output logic               vSync,
  output logic               dataEnable,
  output logic               dataEnableNext,
  output logic               frameStart,
  output logic               lineStart
);

  localparam int   H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int   V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam logic SYNC_ON  = SYNC_ACTIVE_HIGH;
  localparam logic SYNC_OFF = !SYNC_ACTIVE_HIGH;

  if (H_TOTAL > (1 << H_CNT_W)) begin : gHTotalTooWide
    $error("H_TOTAL does not fit the horizontal counter width");
  end
  if (V_TOTAL > (1 << V_CNT_W)) begin : gVTotalTooWide
    $error("V_TOTAL does not fit the vertical counter width");
  end

  seqState_e state_q, state_d;

  logic               counterClear;
  logic               hWrap, vWrap, lastPos;
  logic               hActNext, vActNext, hSyncNext, vSyncNext;
  logic [H_CNT_W-1:0] hNext;
  logic [V_CNT_W-1:0] vNext;
  logic               showNext, deNext;

  logic running_q, dataEnable_q, hSync_q, vSync_q, frameStart_q, lineStart_q;

  timing_axis_counter #(
    .WIDTH (H_CNT_W),
    .TOTAL (H_TOTAL),
    .ACTIVE(H_ACTIVE),
    .FRONT (H_FRONT),
    .SYNC  (H_SYNC)
  ) uHCounter (
    .clk_i       (pixelCLK),
    .reset_i     (reset),
    .clear_i     (counterClear),
    .advance_i   (1'b1),
    .count_o     (hPosCounter),
    .countNext_o (hNext),
    .wrap_o      (hWrap),
    .activeNext_o(hActNext),
    .syncNext_o  (hSyncNext)
  );

  timing_axis_counter #(
    .WIDTH (V_CNT_W),
    .TOTAL (V_TOTAL),
    .ACTIVE(V_ACTIVE),
    .FRONT (V_FRONT),
    .SYNC  (V_SYNC)
  ) uVCounter (
    .clk_i       (pixelCLK),
    .reset_i     (reset),
    .clear_i     (counterClear),
    .advance_i   (hWrap),
    .count_o     (vPosCounter),
    .countNext_o (vNext),
    .wrap_o      (vWrap),
    .activeNext_o(vActNext),
    .syncNext_o  (vSyncNext)
  );

  assign lastPos = hWrap && vWrap;

  // DRAIN keeps the frame going; returning to RUN at the last position wins over IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (runEnable) state_d = RUN;
      RUN:     if (!runEnable) state_d = DRAIN;
      DRAIN: begin
        if (runEnable) begin
          state_d = RUN;
        end else if (lastPos) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign counterClear = (state_q == IDLE) || (state_d == IDLE);
  assign showNext     = !reset && (state_d != IDLE);
  assign deNext       = showNext && hActNext && vActNext;

  // Prefetch hint is the exact next dataEnable, so it follows runEnable combinationally.
  assign dataEnableNext = deNext;

  always_ff @(posedge pixelCLK) begin
    if (reset) begin
      state_q      <= IDLE;
      running_q    <= 1'b0;
      dataEnable_q <= 1'b0;
      hSync_q      <= SYNC_OFF;
      vSync_q      <= SYNC_OFF;
      frameStart_q <= 1'b0;
      lineStart_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      running_q    <= showNext;
      dataEnable_q <= deNext;
      hSync_q      <= (showNext && hSyncNext) ? SYNC_ON : SYNC_OFF;
      vSync_q      <= (showNext && vSyncNext) ? SYNC_ON : SYNC_OFF;
      frameStart_q <= showNext && (hNext == '0) && (vNext == '0);
      lineStart_q  <= showNext && (hNext == '0);
    end
  end

  assign running    = running_q;
  assign dataEnable = dataEnable_q;
  assign hSync      = hSync_q;
  assign vSync      = vSync_q;
  assign frameStart = frameStart_q;
  assign lineStart  = lineStart_q;

endmodule

// File: tb/tb_video_timing_sequencer.sv
// Scoreboard bench: a position-arithmetic raster model predicts every cycle's outputs,
// a separate monitor pops the predictions and compares them against the sequencer.
module tb_video_timing_sequencer;

  localparam int  HA  = 8;
  localparam int  HF  = 2;
  localparam int  HS  = 3;
  localparam int  HB  = 3;
  localparam int  VA  = 6;
  localparam int  VF  = 1;
  localparam int  VS  = 2;
  localparam int  VB  = 2;
  localparam int  HT  = HA + HF + HS + HB;
  localparam int  VT  = VA + VF + VS + VB;
  localparam bit  SAH = 1'b1;

  typedef struct packed {
    logic        running;
    logic [10:0] h;
    logic [9:0]  v;
    logic        hs;
    logic        vs;
    logic        de;
    logic        deNext;
    logic        fs;
    logic        ls;
  } exp_t;

  logic        pixelCLK;
  logic        reset;
  logic        runEnable;
  logic        running;
  logic [10:0] hPosCounter;
  logic [9:0]  vPosCounter;
  logic        hSync;
  logic        vSync;
  logic        dataEnable;
  logic        dataEnableNext;
  logic        frameStart;
  logic        lineStart;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   monCycle = 0;

  bit mValid = 0;
  bit mIdle  = 1;
  bit mDrain = 0;
  int mH = 0;
  int mV = 0;

  video_timing_sequencer #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_ACTIVE_HIGH(SAH)
  ) dut (
    .pixelCLK      (pixelCLK),
    .reset         (reset),
    .runEnable     (runEnable),
    .running       (running),
    .hPosCounter   (hPosCounter),
    .vPosCounter   (vPosCounter),
    .hSync         (hSync),
    .vSync         (vSync),
    .dataEnable    (dataEnable),
    .dataEnableNext(dataEnableNext),
    .frameStart    (frameStart),
    .lineStart     (lineStart)
  );

  initial pixelCLK = 1'b0;
  always #5 pixelCLK = ~pixelCLK;

  function automatic exp_t expectOf(input bit idle, input int h, input int v);
    exp_t e;
    e.running = !idle;
    e.h       = 11'(h);
    e.v       = 10'(v);
    e.de      = !idle && (h < HA) && (v < VA);
    e.hs      = (!idle && h >= HA + HF && h < HA + HF + HS) ? SAH : !SAH;
    e.vs      = (!idle && v >= VA + VF && v < VA + VF + VS) ? SAH : !SAH;
    e.fs      = !idle && (h == 0) && (v == 0);
    e.ls      = !idle && (h == 0);
    e.deNext  = 1'b0;
    return e;
  endfunction

  // One pixel cycle: drive inputs, predict what the DUT shows now and where it goes next.
  task automatic applyStimulus(input bit rst, input bit en);
    bit   nIdle, nDrain;
    int   nH, nV, pos;
    exp_t e;
    @(posedge pixelCLK);
    #1;
    reset     = rst;
    runEnable = en;
    nIdle = 1; nDrain = 0; nH = 0; nV = 0;
    if (rst || !mValid) begin
      nIdle = 1;
    end else if (mIdle) begin
      nIdle = !en;
    end else if (mDrain && !en && mH == HT - 1 && mV == VT - 1) begin
      nIdle = 1;
    end else begin
      pos    = (mV * HT + mH + 1) % (HT * VT);
      nH     = pos % HT;
      nV     = pos / HT;
      nIdle  = 0;
      nDrain = !en;
    end
    if (mValid) begin
      e        = expectOf(mIdle, mH, mV);
      e.deNext = expectOf(nIdle, nH, nV).de;
      sb.push_back(e);
    end
    mValid = 1;
    mIdle  = nIdle;
    mDrain = nDrain;
    mH     = nH;
    mV     = nV;
  endtask

  task automatic runUntil(input bit en, input int th, input int tv);
    int n;
    n = 0;
    while (!(!mIdle && mH == th && mV == tv) && n < 3 * HT * VT) begin
      applyStimulus(1'b0, en);
      n++;
    end
  endtask

  task automatic checkField(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("[TB] FAIL %s cycle=%0d got=%0d want=%0d", name, monCycle, act, want);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkField("running",        int'(running),        int'(e.running));
    checkField("hPosCounter",    int'(hPosCounter),    int'(e.h));
    checkField("vPosCounter",    int'(vPosCounter),    int'(e.v));
    checkField("hSync",          int'(hSync),          int'(e.hs));
    checkField("vSync",          int'(vSync),          int'(e.vs));
    checkField("dataEnable",     int'(dataEnable),     int'(e.de));
    checkField("dataEnableNext", int'(dataEnableNext), int'(e.deNext));
    checkField("frameStart",     int'(frameStart),     int'(e.fs));
    checkField("lineStart",      int'(lineStart),      int'(e.ls));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge pixelCLK);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput(e);
        monCycle++;
      end
    end
  end

  initial begin : driver
    bit en;
    reset     = 1'b1;
    runEnable = 1'b0;

    repeat (3) applyStimulus(1'b1, 1'b0);
    repeat (4) applyStimulus(1'b0, 1'b0);

    // Start, then two full frames of continuous video.
    repeat (2 * HT * VT + 1) applyStimulus(1'b0, 1'b1);

    // Stop request mid-frame drains to the end of the frame, then idles.
    runUntil(1'b1, 5, 3);
    applyStimulus(1'b0, 1'b0);
    runUntil(1'b0, HT - 1, VT - 1);
    repeat (10) applyStimulus(1'b0, 1'b0);

    // Drop and reassert within a frame: counting must not be disturbed.
    applyStimulus(1'b0, 1'b1);
    runUntil(1'b1, 0, 1);
    runUntil(1'b0, 0, 4);
    repeat (2 * HT * VT) applyStimulus(1'b0, 1'b1);

    // Stop requested on the very last pixel of a RUN frame, then resumed on the last DRAIN pixel.
    runUntil(1'b1, HT - 1, VT - 1);
    applyStimulus(1'b0, 1'b0);
    runUntil(1'b0, HT - 1, VT - 1);
    applyStimulus(1'b0, 1'b1);
    runUntil(1'b1, 3, 2);
    runUntil(1'b0, HT - 1, VT - 1);
    repeat (5) applyStimulus(1'b0, 1'b0);

    // Reset mid-frame with runEnable held high.
    applyStimulus(1'b0, 1'b1);
    runUntil(1'b1, 7, 4);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    repeat (50) applyStimulus(1'b0, 1'b1);

    en = 1'b1;
    repeat (4000) begin
      if ($urandom_range(0, 59) == 0) en = !en;
      applyStimulus($urandom_range(0, 499) == 0, en);
    end

    @(posedge pixelCLK);
    #6;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("[TB] FAIL scoreboardDrain got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
